// File: rtl/sdram_loader_arb.sv
// sdram_loader_arb
// Slot-based arbiter for the single SDRAM port shared by the BBC core and the
// data_io loader. While idle the core drives the SDRAM combinationally. While
// the loader owns the port, all SDRAM outputs come from registers that only
// change on mem_sync, and the core is held off the bus. Download bytes are
// buffered in a small FIFO and written one per slot; uploads are single
// outstanding reads. CMOS traffic (index 8'hff) never takes the port.
//
// Ports:
//   clk_sys, reset            clock, synchronous active-high reset
//   mem_sync                  one-cycle pulse at the start of each SDRAM slot
//   ioctl_download/upload     loader phase flags
//   ioctl_index/addr/dout     loader target selector, byte address, write data
//   ioctl_wr / ioctl_rd       download byte strobe / upload byte request
//   ioctl_din / ioctl_wait    upload read data / loader backpressure
//   core_adr/we/di            core request for the current slot
//   sdram_adr/we/di           request to the SDRAM controller
//   sdram_do                  read data of previous slot, valid with mem_sync
//   core_hold                 core must stay off the bus
//   overflow                  sticky: a strobe arrived while the FIFO was full
//   dbg_state_o               current arbiter state
//
// Loader handshake: ioctl_wr/ioctl_rd are single-cycle requests. A strobe is
// accepted in the cycle it is high; ioctl_wait high means the loader must not
// issue a further request (FIFO nearly full, or an upload read in flight).
module sdram_loader_arb #(
  parameter int unsigned FIFO_AW       = 2,
  parameter logic [24:0] ROM_BASE      = 25'h080000,
  parameter logic [24:0] IMG_BASE      = 25'h068000,
  parameter int unsigned RELEASE_SLOTS = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        mem_sync,
  input  logic        ioctl_download,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  input  logic [24:0] core_adr,
  input  logic        core_we,
  input  logic [7:0]  core_di,
  output logic [24:0] sdram_adr,
  output logic        sdram_we,
  output logic [7:0]  sdram_di,
  input  logic [7:0]  sdram_do,
  output logic        core_hold,
  output logic        overflow,
  output logic [2:0]  dbg_state_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned RCW   = (RELEASE_SLOTS > 1) ? $clog2(RELEASE_SLOTS) : 1;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] WAIT_CNT = (FIFO_AW+1)'(DEPTH - 1);
  localparam logic [RCW-1:0]   REL_LAST = RCW'(RELEASE_SLOTS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DL      = 3'd1,
    UL      = 3'd2,
    DRAIN   = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [24:0]        base_q;
  logic [24:0]        fifo_adr_q [DEPTH];
  logic [7:0]         fifo_dat_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [24:0]        adr_q;
  logic               we_q;
  logic [7:0]         di_q;
  logic               pend_q, issued_q;
  logic [24:0]        rd_adr_q;
  logic [7:0]         din_q;
  logic               ovf_q;
  logic [RCW-1:0]     rel_cnt_q;

  logic        owned, entry_dl, entry_ul, enter;
  logic        fifo_full, fifo_empty;
  logic        push_req, push, pop, rd_req;
  logic [24:0] ld_adr;

  assign owned      = (state_q != IDLE);
  assign entry_dl   = ioctl_download && (ioctl_index != 8'hff);
  assign entry_ul   = ioctl_upload && (ioctl_index != 8'hff);
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  // 25-bit add: loader addresses wrap modulo 2^25.
  assign ld_adr     = base_q + ioctl_addr;
  assign push_req   = (state_q == DL) && ioctl_wr;
  assign push       = push_req && !fifo_full;
  // Only the FIFO occupancy before this cycle counts, so a byte pushed in a
  // mem_sync cycle waits for the next slot.
  assign pop        = mem_sync && !fifo_empty && ((state_q == DL) || (state_q == DRAIN));
  assign rd_req     = (state_q == UL) && ioctl_rd && !pend_q;

  // Base is latched whenever we move from a non-loader state into DL/UL.
  assign enter = ((state_q == IDLE) || (state_q == RELEASE)) &&
                 ((state_d == DL) || (state_d == UL));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (entry_dl)      state_d = DL;
        else if (entry_ul) state_d = UL;
      end
      DL: begin
        if (!ioctl_download) state_d = DRAIN;
      end
      UL: begin
        if (!ioctl_upload && !pend_q) state_d = RELEASE;
      end
      DRAIN: begin
        if (mem_sync && fifo_empty) state_d = RELEASE;
      end
      RELEASE: begin
        if (entry_dl)                            state_d = DL;
        else if (entry_ul)                       state_d = UL;
        else if (mem_sync && rel_cnt_q == REL_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      di_q      <= '0;
      pend_q    <= 1'b0;
      issued_q  <= 1'b0;
      rd_adr_q  <= '0;
      din_q     <= '0;
      ovf_q     <= 1'b0;
      rel_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if (enter) base_q <= (ioctl_index == 8'h00) ? ROM_BASE : IMG_BASE;

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (push_req && fifo_full) ovf_q <= 1'b1;

      if (rd_req) begin
        rd_adr_q <= ld_adr;
        pend_q   <= 1'b1;
        issued_q <= 1'b0;
      end

      // Owned slot registers change only at slot starts; an unused slot
      // keeps the address and drops the write enable.
      if (owned && mem_sync) begin
        we_q <= 1'b0;
        if (pop) begin
          adr_q <= fifo_adr_q[rd_ptr_q];
          di_q  <= fifo_dat_q[rd_ptr_q];
          we_q  <= 1'b1;
        end else if ((state_q == UL) && pend_q && !issued_q) begin
          adr_q    <= rd_adr_q;
          issued_q <= 1'b1;
        end else if ((state_q == UL) && pend_q && issued_q) begin
          // sdram_do now carries the data of the slot the read was issued in.
          din_q    <= sdram_do;
          pend_q   <= 1'b0;
          issued_q <= 1'b0;
        end
      end

      if ((state_q != RELEASE) && (state_d == RELEASE)) begin
        rel_cnt_q <= '0;
      end else if ((state_q == RELEASE) && (state_d == RELEASE) && mem_sync) begin
        rel_cnt_q <= rel_cnt_q + 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_adr_q[wr_ptr_q] <= ld_adr;
      fifo_dat_q[wr_ptr_q] <= ioctl_dout;
    end
  end

  assign sdram_adr   = owned ? adr_q : core_adr;
  assign sdram_we    = owned ? we_q  : core_we;
  assign sdram_di    = owned ? di_q  : core_di;
  assign core_hold   = owned;
  assign ioctl_din   = din_q;
  assign overflow    = ovf_q;
  assign ioctl_wait  = (count_q >= WAIT_CNT) || pend_q ||
                       ((state_q == UL) && ioctl_rd);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sdram_loader_arb.sv
// Testbench for sdram_loader_arb: directed steps plus randomized download
// rounds checked against a queue-based model of the write FIFO.
module tb_sdram_loader_arb;

  localparam int          DEPTH         = 4;
  localparam logic [24:0] ROM_BASE      = 25'h080000;
  localparam logic [24:0] IMG_BASE      = 25'h068000;
  localparam int          RELEASE_SLOTS = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        mem_sync = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [24:0] core_adr = '0;
  logic        core_we = 1'b0;
  logic [7:0]  core_di = '0;
  logic [24:0] sdram_adr;
  logic        sdram_we;
  logic [7:0]  sdram_di;
  logic [7:0]  sdram_do = '0;
  logic        core_hold;
  logic        overflow;
  logic [2:0]  dbg_state;

  sdram_loader_arb dut (
    .clk_sys(clk), .reset(reset), .mem_sync(mem_sync),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .core_adr(core_adr), .core_we(core_we), .core_di(core_di),
    .sdram_adr(sdram_adr), .sdram_we(sdram_we), .sdram_di(sdram_di),
    .sdram_do(sdram_do), .core_hold(core_hold), .overflow(overflow),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: exp_q holds {addr,data} of writes the model predicts,
  // obs_q holds writes seen on the SDRAM port while the loader owns it.
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [32:0] mdl_q[$];
  logic [24:0] mdl_base = '0;
  bit          mdl_on = 1'b0;
  bit          ovf_exp = 1'b0;
  bit          ms_prev = 1'b0;

  always @(posedge clk) ms_prev <= mem_sync;
  always @(negedge clk) begin
    if (ms_prev && core_hold && sdram_we) obs_q.push_back({sdram_adr, sdram_di});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the FIFO model from the inputs of this cycle, then
  // advance to just after the next rising edge.
  task automatic tick();
    logic [24:0] a;
    bit full;
    if (mdl_on) begin
      full = (mdl_q.size() == DEPTH);
      if (ioctl_download) chk("wait_lvl", ioctl_wait, mdl_q.size() >= DEPTH - 1);
      if (mem_sync && mdl_q.size() != 0) exp_q.push_back(mdl_q.pop_front());
      if (ioctl_wr && ioctl_download) begin
        a = mdl_base + ioctl_addr;
        if (full) ovf_exp = 1'b1;
        else      mdl_q.push_back({a, ioctl_dout});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_slot();
    mem_sync = 1'b1;
    tick();
    mem_sync = 1'b0;
    repeat (7) tick();
  endtask

  // Drop the loader flags and count slots until the core is let back on.
  task automatic finish_xfer(input string tag, output int n);
    ioctl_download = 1'b0;
    ioctl_upload   = 1'b0;
    tick();
    n = 0;
    while (core_hold && n < 20) begin
      run_slot();
      n++;
    end
    chk({tag, "_idle"}, core_hold, 1'b0);
  endtask

  task automatic cmp_queues(input string tag);
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_wr"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [24:0] ua;
    logic [24:0] ea;
    logic [7:0]  ud;

    // reset and idle passthrough
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_hold", core_hold, 1'b0);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_state", dbg_state, 3'd0);
    core_adr = 25'h01234; core_we = 1'b1; core_di = 8'h5A;
    #1;
    chk("pt_adr", sdram_adr, 25'h01234);
    chk("pt_we", sdram_we, 1'b1);
    chk("pt_di", sdram_di, 8'h5A);
    chk("pt_hold", core_hold, 1'b0);
    core_adr = '0; core_we = 1'b0; core_di = '0;
    tick();

    // download index 0, three strobes, slot every 8 cycles
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    chk("dl_hold", core_hold, 1'b1);
    chk("dl_radr", sdram_adr, 25'h0);
    chk("dl_rwe", sdram_we, 1'b0);
    chk("dl_rdi", sdram_di, 8'h00);
    mdl_base = ROM_BASE; mdl_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'(i); ioctl_dout = 8'(8'h11 * (i + 1)); ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      tick();
    end
    chk("dl_wait3", ioctl_wait, 1'b1);
    for (int i = 0; i < 3; i++) begin
      mem_sync = 1'b1;
      tick();
      mem_sync = 1'b0;
      chk("dl_we", sdram_we, 1'b1);
      chk("dl_adr", sdram_adr, 64'(ROM_BASE) + 64'(i));
      chk("dl_di", sdram_di, 64'(8'h11 * (i + 1)));
      repeat (7) tick();
    end
    finish_xfer("dl0", n);
    chk("dl0_rel_slots", n, RELEASE_SLOTS + 1);
    mdl_on = 1'b0;
    cmp_queues("dl0");

    // randomized download rounds
    for (int r = 0; r < 4; r++) begin
      ioctl_index = (r == 0) ? 8'h00 : 8'($urandom_range(1, 254));
      mdl_base = (ioctl_index == 8'h00) ? ROM_BASE : IMG_BASE;
      ioctl_download = 1'b1;
      tick();
      mdl_on = 1'b1;
      for (int c = 0; c < 60; c++) begin
        ioctl_wr   = ($urandom_range(0, 2) == 0);
        ioctl_addr = ($urandom_range(0, 3) == 0) ? (25'h1ffffff - 25'($urandom_range(0, 7)))
                                                 : 25'($urandom);
        ioctl_dout = 8'($urandom);
        mem_sync   = ($urandom_range(0, 3) == 0);
        tick();
      end
      ioctl_wr = 1'b0; mem_sync = 1'b0;
      finish_xfer("rnd", n);
      mdl_on = 1'b0;
      chk("rnd_ovf", overflow, ovf_exp);
      cmp_queues("rnd");
    end

    // overflow clears only on reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovf_clr", overflow, 1'b0);
    ovf_exp = 1'b0;

    // six back-to-back strobes with no slot
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    mdl_base = ROM_BASE; mdl_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl_addr = 25'h100 + 25'(i); ioctl_dout = 8'($urandom); ioctl_wr = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_wait", ioctl_wait, 1'b1);
    repeat (6) run_slot();
    finish_xfer("ovf", n);
    mdl_on = 1'b0;
    chk("ovf_4wr", obs_q.size(), 4);
    cmp_queues("ovf");
    chk("ovf_sticky", overflow, 1'b1);

    // upload index 1, addr 5
    ioctl_index = 8'h01; ioctl_upload = 1'b1;
    tick();
    chk("ul_hold", core_hold, 1'b1);
    ioctl_addr = 25'd5; ioctl_rd = 1'b1;
    #1;
    chk("ul_wait_rd", ioctl_wait, 1'b1);
    tick();
    ioctl_rd = 1'b0;
    chk("ul_wait_pend", ioctl_wait, 1'b1);
    mem_sync = 1'b1;
    tick();
    mem_sync = 1'b0;
    chk("ul_adr", sdram_adr, 25'h068005);
    chk("ul_we", sdram_we, 1'b0);
    repeat (7) tick();
    chk("ul_wait_mid", ioctl_wait, 1'b1);
    sdram_do = 8'hC3; mem_sync = 1'b1;
    tick();
    mem_sync = 1'b0; sdram_do = 8'h00;
    chk("ul_din", ioctl_din, 8'hC3);
    chk("ul_wait_done", ioctl_wait, 1'b0);

    // randomized reads; a second request while pending must be ignored
    for (int k = 0; k < 4; k++) begin
      ua = 25'($urandom); ud = 8'($urandom);
      ioctl_addr = ua; ioctl_rd = 1'b1;
      tick();
      ioctl_addr = ua ^ 25'h1;
      tick();
      ioctl_rd = 1'b0;
      repeat (k) tick();
      mem_sync = 1'b1;
      tick();
      mem_sync = 1'b0;
      ea = IMG_BASE + ua;
      chk("ulr_adr", sdram_adr, ea);
      repeat (3) tick();
      sdram_do = ud; mem_sync = 1'b1;
      tick();
      mem_sync = 1'b0; sdram_do = 8'h00;
      chk("ulr_din", ioctl_din, ud);
      chk("ulr_wait", ioctl_wait, 1'b0);
    end
    finish_xfer("ul", n);
    chk("ul_rel_slots", n, RELEASE_SLOTS);
    cmp_queues("ul");

    // CMOS index is never arbitrated
    ioctl_index = 8'hff; ioctl_download = 1'b1;
    core_adr = 25'h0abcde; core_we = 1'b1; core_di = 8'h77;
    repeat (3) tick();
    ioctl_wr = 1'b1; mem_sync = 1'b1;
    tick();
    ioctl_wr = 1'b0; mem_sync = 1'b0;
    chk("ff_state", dbg_state, 3'd0);
    chk("ff_hold", core_hold, 1'b0);
    chk("ff_adr", sdram_adr, 25'h0abcde);
    chk("ff_we", sdram_we, 1'b1);
    chk("ff_di", sdram_di, 8'h77);
    ioctl_download = 1'b0; core_adr = '0; core_we = 1'b0; core_di = '0;
    tick();

    // reset with two queued writes
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    ioctl_addr = 25'd7; ioctl_dout = 8'hA7; ioctl_wr = 1'b1;
    tick();
    ioctl_addr = 25'd8; ioctl_dout = 8'hA8;
    tick();
    ioctl_wr = 1'b0;
    obs_q.delete();
    reset = 1'b1; ioctl_download = 1'b0;
    tick();
    chk("mrst_hold", core_hold, 1'b0);
    chk("mrst_wait", ioctl_wait, 1'b0);
    chk("mrst_ovf", overflow, 1'b0);
    chk("mrst_din", ioctl_din, 8'h00);
    chk("mrst_state", dbg_state, 3'd0);
    chk("mrst_we", sdram_we, 1'b0);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      mem_sync = 1'b1;
      tick();
      mem_sync = 1'b0;
      chk("mrst_slot_we", sdram_we, 1'b0);
      repeat (7) tick();
    end
    chk("mrst_nwr", obs_q.size(), 0);
    chk("mrst_hold2", core_hold, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
